// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as
// start bit, LSB-first data, optional even parity and one stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                r_state, w_state_next;
  logic [BW-1:0]         r_baud, w_baud_next, w_baud_step;
  logic [IW-1:0]         r_bit_idx, w_bit_idx_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  r_parity, w_parity_next;
  logic                  r_tx, w_tx_next;
  logic                  w_baud_last;

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_baud_step = w_baud_last ? '0 : r_baud + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    case (r_state)
      S_IDLE:  if (tx_enable && !fifo_empty) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD: begin
        w_shift_next   = fifo_out;
        w_parity_next  = ^fifo_out;
        w_baud_next    = '0;
        w_bit_idx_next = '0;
        w_state_next   = S_START;
      end
      S_START: begin
        w_baud_next = w_baud_step;
        if (w_baud_last) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_baud_next = w_baud_step;
        if (w_baud_last) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == IDX_LAST)
            w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_baud_next = w_baud_step;
        if (w_baud_last) w_state_next = S_STOP;
      end
      S_STOP: begin
        w_baud_next = w_baud_step;
        if (w_baud_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // The line level is derived from the state being entered so tx is a
    // plain register that moves on the same edge as the state.
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
    end
  end

  // Strobes are decoded from registered state only, so reset clears them at once.
  assign tx           = r_tx;
  assign busy         = (r_state != S_IDLE);
  assign fifo_read_en = (r_state == S_FETCH);
  assign frame_done   = (r_state == S_STOP) && w_baud_last;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by
// queue-based FIFO models, with a bit-centre line receiver per instance.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int MAXF = 128;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tx_en      [2];
  logic        fifo_empty [2] = '{1'b1, 1'b1};
  logic [7:0]  fifo_out   [2] = '{8'h00, 8'h00};
  logic        rd_en [2], tx_w [2], busy_w [2], fd_w [2];
  logic [2:0]  st_w [2];
  logic        wr_en [2] = '{1'b0, 1'b0};
  logic [7:0]  wr_data [2] = '{8'h00, 8'h00};
  logic [7:0]  fq0 [$];
  logic [7:0]  fq1 [$];
  logic [10:0] exp_q [$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int pops [2] = '{0, 0};
  int bad_pops [2] = '{0, 0};
  int starts [2] = '{0, 0};
  int done [2] = '{0, 0};
  int start_cyc [2][MAXF];
  logic [10:0] cap_line [2][MAXF];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_out(fifo_out[0]), .fifo_read_en(rd_en[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .frame_done(fd_w[0]), .dbg_state(st_w[0]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_out(fifo_out[1]), .fifo_read_en(rd_en[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .frame_done(fd_w[1]), .dbg_state(st_w[1]));

  // FIFO models: pop when read_en seen with data present, registered out/empty.
  always @(posedge clk) begin
    if (rd_en[0] === 1'b1) begin
      pops[0]++;
      if (fq0.size() == 0) bad_pops[0]++;
      else fifo_out[0] <= fq0.pop_front();
    end
    if (wr_en[0]) fq0.push_back(wr_data[0]);
    fifo_empty[0] <= (fq0.size() == 0);
  end

  always @(posedge clk) begin
    if (rd_en[1] === 1'b1) begin
      pops[1]++;
      if (fq1.size() == 0) bad_pops[1]++;
      else fifo_out[1] <= fq1.pop_front();
    end
    if (wr_en[1]) fq1.push_back(wr_data[1]);
    fifo_empty[1] <= (fq1.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bit-slot sequence: slot 0 start, slots 1..8 data LSB first,
  // then the even-parity bit when enabled, then the stop bit.
  function automatic logic [10:0] model_line(input logic [7:0] d, input int pen);
    logic [10:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[1+i] = d[i];
    if (pen != 0) begin
      l[9]  = 1'(($countones(d) % 2) == 1);
      l[10] = 1'b1;
    end else begin
      l[9] = 1'b1;
    end
    return l;
  endfunction

  task automatic monitor(input int k);
    int nb, bad, idx;
    logic prev, aborted;
    logic [10:0] line;
    logic samp [44];
    nb = (k == 0) ? 10 : 11;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && prev === 1'b1 && tx_w[k] === 1'b0) begin
        idx = starts[k];
        start_cyc[k][idx] = cyc;
        starts[k]++;
        line = '0; bad = 0; aborted = 1'b0;
        for (int j = 0; j < nb * CPB; j++) begin
          if (j > 0) @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          samp[j] = tx_w[k];
          if (j % CPB == CPB / 2) line[j/CPB] = tx_w[k];
          if (busy_w[k] !== 1'b1) bad++;
          if (fd_w[k] !== (j == nb * CPB - 1)) bad++;
          if (rd_en[k] !== 1'b0) bad++;
        end
        if (!aborted) begin
          for (int j = 0; j < nb * CPB; j++)
            if (samp[j] !== line[j/CPB]) bad++;
          @(negedge clk);
          if (busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) bad++;
          cap_line[k][idx] = line;
          chk($sformatf("frame_shape%0d", k), bad, 0);
          done[k]++;
        end
      end
      prev = tx_w[k];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push_word(input int k, input logic [7:0] d);
    @(negedge clk);
    wr_en[k] = 1'b1;
    wr_data[k] = d;
    @(negedge clk);
    wr_en[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (done[k] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_frames%0d", k), done[k] >= target, 1);
  endtask

  task automatic wait_starts(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (starts[k] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_start%0d", k), starts[k] >= target, 1);
  endtask

  initial begin
    vec_t vecs [6];
    int b0, b1, p0, p1, st, guard, bad, n;
    logic [7:0] words [8];
    logic [10:0] e;

    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h03, 11'b1_0_00000011_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h00, 11'b1_0_00000000_0};
    vecs[5] = '{8'h80, 11'b1_1_10000000_0};

    tx_en[0] = 1'b0; tx_en[1] = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_tx", tx_w[k], 1);
      chk("reset_busy", busy_w[k], 0);
      chk("reset_read_en", rd_en[k], 0);
      chk("reset_frame_done", fd_w[k], 0);
      chk("reset_state", st_w[k], 0);
    end
    reset_n = 1'b1;

    // Single frames, table driven, on both instances.
    tx_en[0] = 1'b1; tx_en[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0 = done[0]; b1 = done[1]; p0 = pops[0]; p1 = pops[1];
      push_word(0, vecs[i].data);
      push_word(1, vecs[i].data);
      wait_done(0, b0 + 1, 200);
      wait_done(1, b1 + 1, 200);
      repeat (4) @(negedge clk);
      chk("vec_par_line", cap_line[1][b1], vecs[i].line);
      chk("vec_par_model", cap_line[1][b1], model_line(vecs[i].data, 1));
      chk("vec_nopar_line", cap_line[0][b0], model_line(vecs[i].data, 0));
      chk("vec_pops0", pops[0] - p0, 1);
      chk("vec_pops1", pops[1] - p1, 1);
      chk("vec_empty0", fifo_empty[0], 1);
      chk("vec_empty1", fifo_empty[1], 1);
    end

    // Burst of 8 back-to-back frames.
    tx_en[0] = 1'b0;
    b0 = done[0]; p0 = pops[0];
    for (int i = 1; i <= 8; i++) begin
      push_word(0, 8'(i));
      exp_q.push_back(model_line(8'(i), 0));
    end
    tx_en[0] = 1'b1;
    wait_done(0, b0 + 8, 8 * 50 + 50);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      chk("burst_line", cap_line[0][b0+i], e);
      if (i > 0) chk("burst_gap", start_cyc[0][b0+i] - start_cyc[0][b0+i-1], 43);
    end
    chk("burst_pops", pops[0] - p0, 8);
    chk("burst_empty", fifo_empty[0], 1);

    // tx_enable gating.
    tx_en[0] = 1'b0;
    b0 = done[0]; p0 = pops[0];
    push_word(0, 8'h11); push_word(0, 8'h22); push_word(0, 8'h33);
    repeat (60) @(negedge clk);
    chk("gate_no_pop", pops[0] - p0, 0);
    chk("gate_no_frame", done[0] - b0, 0);
    tx_en[0] = 1'b1;
    wait_starts(0, b0 + 2, 200);
    tx_en[0] = 1'b0;
    repeat (150) @(negedge clk);
    chk("gate_frames", done[0] - b0, 2);
    chk("gate_pops", pops[0] - p0, 2);
    chk("gate_left", fq0.size(), 1);
    chk("gate_line0", cap_line[0][b0], model_line(8'h11, 0));
    chk("gate_line1", cap_line[0][b0+1], model_line(8'h22, 0));
    tx_en[0] = 1'b1;
    wait_done(0, b0 + 3, 120);
    chk("gate_line2", cap_line[0][b0+2], model_line(8'h33, 0));
    repeat (4) @(negedge clk);

    // FIFO turns non-empty on the very edge that ends STOP.
    b0 = starts[0];
    push_word(0, 8'h5A);
    wait_starts(0, b0 + 1, 100);
    st = start_cyc[0][b0];
    guard = 0;
    while (cyc != st + 39 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("sim_align", cyc, st + 39);
    wr_en[0] = 1'b1; wr_data[0] = 8'hC3;
    @(negedge clk);
    wr_en[0] = 1'b0;
    chk("sim_idle_state", st_w[0], 0);
    chk("sim_idle_busy", busy_w[0], 0);
    @(negedge clk);
    chk("sim_fetch_state", st_w[0], 1);
    chk("sim_fetch_read", rd_en[0], 1);
    wait_done(0, b0 + 2, 150);
    chk("sim_gap", start_cyc[0][b0+1] - st, 43);
    chk("sim_line0", cap_line[0][b0], model_line(8'h5A, 0));
    chk("sim_line1", cap_line[0][b0+1], model_line(8'hC3, 0));
    repeat (4) @(negedge clk);

    // Random words on both instances against the model.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 6);
      b0 = done[0]; b1 = done[1];
      tx_en[1] = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        words[i] = 8'($urandom_range(0, 255));
        push_word(0, words[i]);
        push_word(1, words[i]);
        exp_q.push_back(model_line(words[i], 1));
      end
      tx_en[1] = 1'b1;
      wait_done(0, b0 + n, n * 60 + 60);
      wait_done(1, b1 + n, n * 60 + 60);
      for (int i = 0; i < n; i++) begin
        chk("rnd_nopar", cap_line[0][b0+i], model_line(words[i], 0));
        e = exp_q.pop_front();
        chk("rnd_par", cap_line[1][b1+i], e);
      end
      repeat (4) @(negedge clk);
    end

    // Reset in the middle of DATA.
    b0 = starts[0];
    push_word(0, 8'hE7);
    wait_starts(0, b0 + 1, 100);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy_w[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx", tx_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_read_en", rd_en[0], 0);
    chk("rst_frame_done", fd_w[0], 0);
    chk("rst_state", st_w[0], 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    p0 = pops[0]; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) bad++;
    end
    chk("post_rst_tx_idle", bad, 0);
    chk("post_rst_no_pop", pops[0] - p0, 0);
    chk("post_rst_empty", fifo_empty[0], 1);
    chk("bad_pops0", bad_pops[0], 0);
    chk("bad_pops1", bad_pops[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for `synchronous_fifo`. It pops words from the FIFO read port one at a time and serialises each one onto an asynchronous serial line: one start bit, DATA_WIDTH data bits LSB first, an optional even-parity bit, and one stop bit. It drives the FIFO's `read_en` and consumes its `out` and `empty`. It is the first block that turns buffered parallel data into a pin-level stream.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width and number of data bits per frame.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2 or more.
- `PARITY_EN`, default 0: 0 means no parity bit; 1 inserts an even-parity bit after the data bits.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_enable`  in  1  when high, the block may start new frames.
- `fifo_empty`  in  1  from the FIFO `empty` output.
- `fifo_out`  in  DATA_WIDTH  from the FIFO `out` output.
- `fifo_read_en`  out  1  to the FIFO `read_en` input; a one-cycle pop strobe.
- `tx`  out  1  serial line; idles high. Registered.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the final cycle of the stop bit.

## Operation
- **FIFO contract.** The FIFO pops at an edge where it samples `read_en`=1 and `empty`=0. It presents that word on `out` from that edge onward, registered.
- **States.** IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- **IDLE.** If `tx_enable`=1 and `fifo_empty`=0, go to FETCH. Otherwise stay in IDLE.
- **FETCH.** `fifo_read_en`=1 for exactly this one cycle, decoded from the state. Always go to LOAD.
- **LOAD.** Capture `fifo_out` into the shift register. Compute parity as the XOR of the data bits. Clear the baud counter and the bit index. Go to START.
- **START.** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA.** `tx` = shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- **PARITY.** `tx` = parity bit for CLKS_PER_BIT cycles, then go to STOP. The parity bit makes the total count of ones across data plus parity even.
- **STOP.** `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 on the last cycle. Then go to IDLE.
- **Counter widths.** The baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0 to CLKS_PER_BIT-1. The bit index is $clog2(DATA_WIDTH+1) bits wide.
- **`tx_enable` dropped mid-frame.** The current frame completes unchanged. No new FETCH occurs until `tx_enable` returns high.
- **`fifo_empty` mid-frame.** Ignored. It is only sampled in IDLE.
- **No popping from an empty FIFO.** `fifo_read_en` is never high while in a state reached with `fifo_empty`=1.
- **Reset.**
  - Asynchronous assertion forces: state=IDLE, `tx`=1, `busy`=0, `fifo_read_en`=0, `frame_done`=0, counters=0.
  - Reset in the middle of a frame abandons that frame; the word already popped is lost.
  - After release, the block idles until the next edge that sees the IDLE start condition.

## Timing
- **Pop latency.** Let E0 be the edge at which IDLE sees `tx_enable`=1 and `fifo_empty`=0.
  - FETCH runs from E0 to E1; the FIFO pops at E1.
  - LOAD runs from E1 to E2, with `fifo_out` valid during it.
  - `tx` falls at E2.
- **Frame length.** `tx` is low or driving data from E2 for (1+DATA_WIDTH+PARITY_EN+1)·CLKS_PER_BIT cycles. This count includes the stop bit.
- **Back-to-back frames.** The next start bit falls exactly 3 cycles after the stop bit ends (IDLE, FETCH, LOAD), with `tx` high during those cycles.
- **`busy`.**
  - Rises at E0.
  - Falls at the edge that leaves STOP.
  - Stays low for at least 1 cycle between frames.
- **Output hazards.** `tx` changes only on clock edges and has no combinational path from the inputs.
- **Throughput (default parameters).** One word per 10·16+3 = 163 cycles.

## Test plan
- **Reset values.** Assert `reset_n`=0 mid-DATA. Required: `tx`=1, `busy`=0 and `fifo_read_en`=0 immediately (asynchronously). After release with the FIFO empty: no `fifo_read_en` pulse and `tx` stays 1 for 100 cycles.
- **Single frame (DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0).** Write 0xA5 into the FIFO.
  - Required: exactly one `fifo_read_en` pulse.
  - `tx` samples taken at bit centres read 0, 1,0,1,0,0,1,0,1, 1, giving 40 cycles of frame.
  - `frame_done` pulses once; FIFO `empty`=1 afterwards.
- **Burst of 8 (drains the full FIFO).** Write 0x01–0x08.
  - Required: 8 frames decoded by a bench receiver in order, 0x01 to 0x08.
  - Each start bit begins 3 cycles after the previous stop bit ends.
  - Exactly 8 `fifo_read_en` pulses; `empty`=1 at the end.
- **Parity (PARITY_EN=1).** Send 0x07 and then 0x03.
  - 0x07 has three ones, so the parity bit is 1.
  - 0x03 has two ones, so the parity bit is 0.
  - Each frame is 44 cycles.
- **`tx_enable` gating.** Hold `tx_enable`=0 with 3 words in the FIFO.
  - Required: no pops while it is low.
  - Raise it, then drop it during the second frame: exactly 2 frames complete and 1 word remains in the FIFO.
- **Simultaneous events.** The FIFO becomes non-empty in the same cycle that STOP ends. Required: the block passes through IDLE for one cycle, then FETCH, and the start bit occurs 3 cycles after the stop bit.
